// File: rtl/pc_stack_counter.sv
// pc_stack_counter
// Parameterised program counter with an integrated return-address stack.
// Drives the instruction-memory address bus and is controlled by the
// microcode sequencer. One command is accepted per clock. Priority is
// call > ret > load > incpc. Stack misuse is recorded in two sticky flags,
// ovf and unf, which clr_err clears.

module pc_stack_counter #(
   parameter int WIDTH = 12,
   parameter int DEPTH = 4,
   localparam int SPW  = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] D,
   input  logic             load,
   input  logic             incpc,
   input  logic             call,
   input  logic             ret,
   input  logic             clr_err,
   output logic [WIDTH-1:0] Q,
   output logic             rco,
   output logic [WIDTH-1:0] tos,
   output logic [SPW-1:0]   sp,
   output logic             empty,
   output logic             full,
   output logic             ovf,
   output logic             unf
);

   // The decoded command for the current cycle, after priority resolution
   typedef enum logic [2:0] {
      CMD_NONE,
      CMD_CALL,
      CMD_RET,
      CMD_LOAD,
      CMD_INC
   } cmd_e;

   cmd_e cmd;

   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pc_plus_one;
   logic [WIDTH-1:0] stack_q [DEPTH];
   logic [WIDTH-1:0] stack_d [DEPTH];
   logic [SPW-1:0]   sp_q, sp_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;

   // The push slot is the low bits of sp. A push never happens when full,
   // so the MSB of sp is not needed there. The top slot is sp-1 taken in
   // the same low bits. When sp == DEPTH the low bits are zero, and the
   // subtraction wraps to DEPTH-1, which is the correct top entry.
   logic [SPW-2:0]   push_idx;
   logic [SPW-2:0]   top_idx;
   logic             is_empty;
   logic             is_full;
   logic             ovf_set;
   logic             unf_set;

   assign pc_plus_one = pc_q + WIDTH'(1);
   assign push_idx    = sp_q[SPW-2:0];
   assign top_idx     = sp_q[SPW-2:0] - (SPW-1)'(1);
   assign is_empty    = (sp_q == '0);
   assign is_full     = (sp_q == SPW'(DEPTH));

   // Resolve the fixed command priority so that only one action is taken
   always_comb begin
      cmd = CMD_NONE;
      if (call) begin
         cmd = CMD_CALL;
      end else if (ret) begin
         cmd = CMD_RET;
      end else if (load) begin
         cmd = CMD_LOAD;
      end else if (incpc) begin
         cmd = CMD_INC;
      end
   end

   // Compute the next PC, the next stack contents and the next stack pointer
   always_comb begin
      pc_d    = pc_q;
      stack_d = stack_q;
      sp_d    = sp_q;
      ovf_set = 1'b0;
      unf_set = 1'b0;
      unique case (cmd)
         CMD_CALL: begin
            pc_d = D;
            if (is_full) begin
               ovf_set = 1'b1;
            end else begin
               stack_d[push_idx] = pc_plus_one;
               sp_d              = sp_q + SPW'(1);
            end
         end
         CMD_RET: begin
            if (is_empty) begin
               unf_set = 1'b1;
            end else begin
               pc_d = stack_q[top_idx];
               sp_d = sp_q - SPW'(1);
            end
         end
         CMD_LOAD: begin
            pc_d = D;
         end
         CMD_INC: begin
            pc_d = pc_plus_one;
         end
         default: begin
            pc_d = pc_q;
         end
      endcase
   end

   // Sticky error flags: a new error in the same cycle wins over clr_err
   always_comb begin
      ovf_d = (ovf_q & ~clr_err) | ovf_set;
      unf_d = (unf_q & ~clr_err) | unf_set;
   end

   // State registers. Asynchronous reset clears the PC, the stack and the flags.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc_q  <= '0;
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
         for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= '0;
         end
      end else begin
         pc_q  <= pc_d;
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
         for (int i = 0; i < DEPTH; i++) begin
            stack_q[i] <= stack_d[i];
         end
      end
   end

   assign Q     = pc_q;
   assign rco   = incpc & (&pc_q);
   assign tos   = is_empty ? '0 : stack_q[top_idx];
   assign sp    = sp_q;
   assign empty = is_empty;
   assign full  = is_full;
   assign ovf   = ovf_q;
   assign unf   = unf_q;

endmodule

// File: tb/tb_pc_stack_counter.sv
// Testbench for pc_stack_counter with WIDTH=12 and DEPTH=4.
// It runs three parts. The first is a table of directed vectors with
// hand-derived expectations. The second is an asynchronous reset sequence.
// The third is randomised traffic compared against a queue-based model.

module tb_pc_stack_counter;

   localparam int WIDTH = 12;
   localparam int DEPTH = 4;
   localparam int SPW   = 3;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] D;
   logic             load, incpc, call, ret, clr_err;
   logic [WIDTH-1:0] Q, tos;
   logic             rco, empty, full, ovf, unf;
   logic [SPW-1:0]   sp;

   int checks;
   int failures;

   pc_stack_counter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .D(D), .load(load), .incpc(incpc), .call(call),
      .ret(ret), .clr_err(clr_err), .Q(Q), .rco(rco), .tos(tos), .sp(sp),
      .empty(empty), .full(full), .ovf(ovf), .unf(unf)
   );

   // Free-running clock with a period of 10 time units
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Watchdog that stops the run if it ever stalls
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic             ld, inc, cl, rt, clr;
      logic [WIDTH-1:0] d;
      logic             expRco;
      logic [WIDTH-1:0] expQ;
      logic [SPW-1:0]   expSp;
      logic [WIDTH-1:0] expTos;
      logic             expOvf, expUnf;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mkVec(logic ld, logic inc, logic cl, logic rt, logic clr,
                                  logic [WIDTH-1:0] d, logic eRco, logic [WIDTH-1:0] eQ,
                                  logic [SPW-1:0] eSp, logic [WIDTH-1:0] eTos,
                                  logic eOvf, logic eUnf);
      vec_t v;
      v.ld = ld; v.inc = inc; v.cl = cl; v.rt = rt; v.clr = clr; v.d = d;
      v.expRco = eRco; v.expQ = eQ; v.expSp = eSp; v.expTos = eTos;
      v.expOvf = eOvf; v.expUnf = eUnf;
      return v;
   endfunction

   // Compare one value and record the result
   task automatic checkVal(input string name, input int idx,
                           input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s[%0d]: actual=0x%0h required=0x%0h", name, idx, act, exp);
      end
   endtask

   // Compare every registered output, plus the flags that follow from sp
   task automatic checkOutput(input int idx, input logic [WIDTH-1:0] eQ,
                              input logic [SPW-1:0] eSp, input logic [WIDTH-1:0] eTos,
                              input logic eOvf, input logic eUnf);
      checkVal("Q", idx, 32'(Q), 32'(eQ));
      checkVal("sp", idx, 32'(sp), 32'(eSp));
      checkVal("tos", idx, 32'(tos), 32'(eTos));
      checkVal("empty", idx, 32'(empty), 32'(eSp == 0));
      checkVal("full", idx, 32'(full), 32'(eSp == SPW'(DEPTH)));
      checkVal("ovf", idx, 32'(ovf), 32'(eOvf));
      checkVal("unf", idx, 32'(unf), 32'(eUnf));
   endtask

   // Drive one command at the falling edge and let the combinational outputs settle
   task automatic applyStimulus(input logic ld, input logic inc, input logic cl,
                                input logic rt, input logic clr, input logic [WIDTH-1:0] d);
      @(negedge clk);
      load = ld; incpc = inc; call = cl; ret = rt; clr_err = clr; D = d;
      #1;
   endtask

   task automatic idleInputs();
      load = 0; incpc = 0; call = 0; ret = 0; clr_err = 0; D = '0;
   endtask

   // Hold reset across a rising edge, then release it at a falling edge
   task automatic doReset();
      @(negedge clk);
      idleInputs();
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Behavioural reference model: the return stack is a queue of addresses
   int unsigned mPc;
   int unsigned mStack[$];
   bit          mOvf, mUnf;

   function automatic void modelReset();
      mPc = 0; mStack.delete(); mOvf = 0; mUnf = 0;
   endfunction

   function automatic void modelStep(logic ld, logic inc, logic cl, logic rt,
                                     logic clr, int unsigned d);
      bit ovfNew = 0, unfNew = 0;
      if (cl) begin
         if (mStack.size() < DEPTH) mStack.push_back((mPc + 1) % 4096);
         else ovfNew = 1;
         mPc = d;
      end else if (rt) begin
         if (mStack.size() > 0) mPc = mStack.pop_back();
         else unfNew = 1;
      end else if (ld) begin
         mPc = d;
      end else if (inc) begin
         mPc = (mPc + 1) % 4096;
      end
      mOvf = (mOvf && !clr) || ovfNew;
      mUnf = (mUnf && !clr) || unfNew;
   endfunction

   function automatic int unsigned modelTos();
      if (mStack.size() == 0) return 0;
      return mStack[mStack.size() - 1];
   endfunction

   initial begin
      logic ld, inc, cl, rt, clr;
      logic [WIDTH-1:0] d;
      int n;
      checks = 0;
      failures = 0;
      rst = 1'b0;
      idleInputs();

      // Directed vectors: ld inc call ret clr D | rco Q sp tos ovf unf
      // Increment across the all-ones boundary
      vecs.push_back(mkVec(1,0,0,0,0, 12'hFFE, 0, 12'hFFE, 0, 12'h000, 0, 0));
      vecs.push_back(mkVec(0,1,0,0,0, 12'h000, 0, 12'hFFF, 0, 12'h000, 0, 0));
      vecs.push_back(mkVec(0,1,0,0,0, 12'h000, 1, 12'h000, 0, 12'h000, 0, 0));
      vecs.push_back(mkVec(0,1,0,0,0, 12'h000, 0, 12'h001, 0, 12'h000, 0, 0));
      // Nested call and return
      vecs.push_back(mkVec(1,0,0,0,0, 12'h100, 0, 12'h100, 0, 12'h000, 0, 0));
      vecs.push_back(mkVec(0,0,1,0,0, 12'h200, 0, 12'h200, 1, 12'h101, 0, 0));
      vecs.push_back(mkVec(0,0,1,0,0, 12'h300, 0, 12'h300, 2, 12'h201, 0, 0));
      vecs.push_back(mkVec(0,0,0,1,0, 12'h000, 0, 12'h201, 1, 12'h101, 0, 0));
      vecs.push_back(mkVec(0,0,0,1,0, 12'h000, 0, 12'h101, 0, 12'h000, 0, 0));
      // Fill the stack, overflow it, then unwind in LIFO order
      vecs.push_back(mkVec(0,0,1,0,0, 12'h111, 0, 12'h111, 1, 12'h102, 0, 0));
      vecs.push_back(mkVec(0,0,1,0,0, 12'h222, 0, 12'h222, 2, 12'h112, 0, 0));
      vecs.push_back(mkVec(0,0,1,0,0, 12'h333, 0, 12'h333, 3, 12'h223, 0, 0));
      vecs.push_back(mkVec(0,0,1,0,0, 12'h444, 0, 12'h444, 4, 12'h334, 0, 0));
      vecs.push_back(mkVec(0,0,1,0,0, 12'h7AB, 0, 12'h7AB, 4, 12'h334, 1, 0));
      vecs.push_back(mkVec(0,0,0,1,0, 12'h000, 0, 12'h334, 3, 12'h223, 1, 0));
      vecs.push_back(mkVec(0,0,0,1,0, 12'h000, 0, 12'h223, 2, 12'h112, 1, 0));
      vecs.push_back(mkVec(0,0,0,1,0, 12'h000, 0, 12'h112, 1, 12'h102, 1, 0));
      vecs.push_back(mkVec(0,0,0,1,0, 12'h000, 0, 12'h102, 0, 12'h000, 1, 0));
      vecs.push_back(mkVec(0,0,0,0,1, 12'h000, 0, 12'h102, 0, 12'h000, 0, 0));
      // Underflow, clear, and a set that wins over a simultaneous clear
      vecs.push_back(mkVec(1,0,0,0,0, 12'h050, 0, 12'h050, 0, 12'h000, 0, 0));
      vecs.push_back(mkVec(0,0,0,1,0, 12'h000, 0, 12'h050, 0, 12'h000, 0, 1));
      vecs.push_back(mkVec(0,0,0,0,1, 12'h000, 0, 12'h050, 0, 12'h000, 0, 0));
      vecs.push_back(mkVec(0,0,0,1,1, 12'h000, 0, 12'h050, 0, 12'h000, 0, 1));
      vecs.push_back(mkVec(0,0,0,0,1, 12'h000, 0, 12'h050, 0, 12'h000, 0, 0));
      // Command priority
      vecs.push_back(mkVec(1,0,0,0,0, 12'h010, 0, 12'h010, 0, 12'h000, 0, 0));
      vecs.push_back(mkVec(1,1,1,1,0, 12'h0AA, 0, 12'h0AA, 1, 12'h011, 0, 0));
      vecs.push_back(mkVec(1,1,0,0,0, 12'h123, 0, 12'h123, 1, 12'h011, 0, 0));
      vecs.push_back(mkVec(0,1,0,1,0, 12'h000, 0, 12'h011, 0, 12'h000, 0, 0));
      // A call from the all-ones address pushes a wrapped return address, and rco still follows incpc
      vecs.push_back(mkVec(1,0,0,0,0, 12'hFFF, 0, 12'hFFF, 0, 12'h000, 0, 0));
      vecs.push_back(mkVec(0,1,1,0,0, 12'h005, 1, 12'h005, 1, 12'h000, 0, 0));
      vecs.push_back(mkVec(0,0,0,1,0, 12'h000, 0, 12'h000, 0, 12'h000, 0, 0));

      // Check the outputs while reset is held
      #2;
      checkOutput(-1, 12'h000, 0, 12'h000, 0, 0);
      checkVal("rcoReset", -1, 32'(rco), 32'(0));
      doReset();

      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].ld, vecs[i].inc, vecs[i].cl, vecs[i].rt, vecs[i].clr, vecs[i].d);
         checkVal("rco", i, 32'(rco), 32'(vecs[i].expRco));
         @(posedge clk);
         #1;
         checkOutput(i, vecs[i].expQ, vecs[i].expSp, vecs[i].expTos,
                     vecs[i].expOvf, vecs[i].expUnf);
      end

      // Asynchronous reset in the middle of operation, applied between clock edges
      applyStimulus(0,0,0,1,0, 12'h000);
      @(posedge clk); #1;
      applyStimulus(0,0,1,0,0, 12'h100);
      @(posedge clk); #1;
      applyStimulus(0,0,1,0,0, 12'h200);
      @(posedge clk); #1;
      applyStimulus(0,0,1,0,0, 12'h4C2);
      @(posedge clk); #1;
      checkOutput(100, 12'h4C2, 3, 12'h201, 0, 1);
      @(negedge clk);
      load = 1; incpc = 1; D = 12'h777;
      #2;
      rst = 1'b0;
      #1;
      checkOutput(101, 12'h000, 0, 12'h000, 0, 0);
      @(posedge clk); #1;
      checkOutput(102, 12'h000, 0, 12'h000, 0, 0);
      @(negedge clk);
      idleInputs();
      incpc = 1;
      rst = 1'b1;
      @(posedge clk); #1;
      checkOutput(103, 12'h001, 0, 12'h000, 0, 0);

      // Randomised traffic against the queue model
      doReset();
      modelReset();
      for (int i = 0; i < 600; i++) begin
         n   = $urandom_range(0, 99);
         cl  = (n < 28);
         rt  = ($urandom_range(0, 99) < 28);
         ld  = ($urandom_range(0, 99) < 20);
         inc = ($urandom_range(0, 99) < 60);
         clr = ($urandom_range(0, 99) < 10);
         n   = $urandom_range(0, 7);
         d   = (n == 0) ? 12'hFFF : (n == 1) ? 12'hFFE : WIDTH'($urandom_range(0, 4095));
         applyStimulus(ld, inc, cl, rt, clr, d);
         checkVal("rndRco", i, 32'(rco), 32'(inc && (mPc == 4095)));
         modelStep(ld, inc, cl, rt, clr, 32'(d));
         @(posedge clk);
         #1;
         checkOutput(1000 + i, WIDTH'(mPc), SPW'(mStack.size()), WIDTH'(modelTos()),
                     mOvf, mUnf);
      end

      idleInputs();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
